// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a channel mux select, samples each channel into a frame word; MUX_SCAN_PARITY_EN adds a frame parity output
module mux_scan_ctrl #(
    parameter int NUM_CH = 13,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mux_in,
    output logic [SEL_W-1:0]  sel_out,
    output logic              busy,
    output logic [NUM_CH-1:0] word,
    output logic              valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
    localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [NUM_CH-1:0] cap, cap_nx;
    always_comb begin
        cap_nx = cap;
        cap_nx[sel_out] = mux_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_out <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            word    <= '0;
            cap     <= '0;
            cnt     <= '0;
`ifdef MUX_SCAN_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_SETTLE;
                    sel_out <= '0;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    cap     <= '0;
                end
                S_SETTLE: if (abort) begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    sel_out <= '0;
                end else if (cnt == CNT_END) begin
                    state <= S_SAMPLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_SAMPLE: if (abort) begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    sel_out <= '0;
                end else begin
                    cap <= cap_nx;
                    // the last channel's bit goes straight into word so valid lands in the DONE cycle
                    if (sel_out == LAST) begin
                        state   <= S_DONE;
                        word    <= cap_nx;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        sel_out <= '0;
`ifdef MUX_SCAN_PARITY_EN
                        parity  <= ^cap_nx;
`endif
                    end else begin
                        state   <= S_SETTLE;
                        sel_out <= sel_out + 1'b1;
                        cnt     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and random scans checked against a frame-timeline model
module tb_mux_scan_ctrl;
    localparam int NUM_CH = 13;
    localparam int SEL_W  = 4;
    localparam int SETTLE = 2;
    localparam int CH_CYC = SETTLE + 1;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, mux_in;
    logic [SEL_W-1:0] sel_out;
    logic busy, valid;
    logic [NUM_CH-1:0] word;
    logic [NUM_CH-1:0] pat = '0;
`ifdef MUX_SCAN_PARITY_EN
    logic parity;
`endif
    int n_chk = 0, n_err = 0, cyc = 0, prev_v = -1;
    bit chk_gap = 0;
    int m_ph = 0, m_e = 0;
    logic [NUM_CH-1:0] m_cap = '0, m_word = '0;
    logic m_par = 1'b0;

    always #5 clk = ~clk;
    assign mux_in = (int'(sel_out) < NUM_CH) ? pat[sel_out] : 1'b0;

    mux_scan_ctrl #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mux_in(mux_in),
        .sel_out(sel_out), .busy(busy), .word(word), .valid(valid)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // model: a frame is a timeline of e cycles since start acceptance; channel = e / CH_CYC
    task automatic step(input logic s, input logic a, input logic r);
        start = s; abort = a; rst = r;
        if (r) begin
            m_ph = 0; m_word = '0; m_par = 1'b0;
        end else if (m_ph == 0) begin
            if (s) begin m_ph = 1; m_e = 0; m_cap = '0; end
        end else if (m_ph == 1) begin
            if (a) m_ph = 0;
            else begin
                if (m_e % CH_CYC == SETTLE) m_cap[m_e / CH_CYC] = pat[m_e / CH_CYC];
                if (m_e == NUM_CH * CH_CYC - 1) begin
                    m_ph = 2; m_word = m_cap; m_par = ^m_cap;
                end else m_e++;
            end
        end else m_ph = 0;
        @(negedge clk);
        cyc++;
        check("sel", 32'(sel_out), m_ph == 1 ? 32'(m_e / CH_CYC) : 32'd0);
        check("sel_rng", 32'(int'(sel_out) < NUM_CH), 32'd1);
        check("busy", 32'(busy), 32'(m_ph == 1));
        check("valid", 32'(valid), 32'(m_ph == 2));
        check("word", 32'(word), 32'(m_word));
`ifdef MUX_SCAN_PARITY_EN
        check("parity", 32'(parity), 32'(m_par));
`endif
        if (valid) begin
            if (chk_gap && prev_v >= 0) check("b2b_gap", 32'(cyc - prev_v), 32'd41);
            prev_v = cyc;
        end
    endtask

    initial begin
        @(negedge clk);
        repeat (3) step(0, 0, 1);
        repeat (20) step(0, 0, 0);
        check("idle_word", 32'(word), 32'h0);
        // single frame
        pat = 13'h15A5;
        step(1, 0, 0);
        repeat (38) step(0, 0, 0);
        check("sf_pre_valid", 32'(valid), 32'd0);
        step(0, 0, 0);
        check("sf_valid", 32'(valid), 32'd1);
        check("sf_word", 32'(word), 32'h15A5);
        check("sf_busy", 32'(busy), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("sf_parity", 32'(parity), 32'd1);
`endif
        repeat (5) step(0, 0, 0);
        // back-to-back with start held
        pat = 13'h1FFF; chk_gap = 1; prev_v = -1;
        step(1, 0, 0);
        for (int i = 0; i < 100 && !valid; i++) step(1, 0, 0);
        check("b2b_v1", 32'(valid), 32'd1);
        check("b2b_w1", 32'(word), 32'h1FFF);
        pat = 13'h0001;
        step(1, 0, 0);
        for (int i = 0; i < 100 && !valid; i++) step(1, 0, 0);
        check("b2b_v2", 32'(valid), 32'd1);
        check("b2b_w2", 32'(word), 32'h0001);
        chk_gap = 0;
        repeat (3) step(0, 0, 0);
        // start while busy
        pat = 13'h0F0F;
        step(1, 0, 0);
        for (int i = 1; i < 39; i++) step(i == 5 || i == 20, 0, 0);
        step(0, 0, 0);
        check("swb_valid", 32'(valid), 32'd1);
        check("swb_word", 32'(word), 32'h0F0F);
        repeat (3) step(0, 0, 0);
        // abort mid-frame
        pat = 13'h0ABC;
        step(1, 0, 0);
        repeat (45) step(0, 0, 0);
        check("ab_prior", 32'(word), 32'h0ABC);
        pat = 13'h1555;
        step(1, 0, 0);
        repeat (14) step(0, 0, 0);
        step(0, 1, 0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_sel", 32'(sel_out), 32'd0);
        repeat (40) step(0, 0, 0);
        check("ab_word", 32'(word), 32'h0ABC);
        step(1, 0, 0);
        repeat (45) step(0, 0, 0);
        check("ab_new", 32'(word), 32'h1555);
        // reset mid-frame
        pat = 13'h0333;
        step(1, 0, 0);
        repeat (19) step(0, 0, 0);
        step(0, 0, 1);
        check("rst_word", 32'(word), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        step(1, 0, 0);
        check("rst_sel0", 32'(sel_out), 32'd0);
        repeat (45) step(0, 0, 0);
        check("rst_new", 32'(word), 32'h0333);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_ph == 0) pat = NUM_CH'($urandom);
            step($urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 400) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
